// File: rtl/nn_out_framer_pkg.sv
// Shared NN NoC register map, CHDR header type and frame-length helper.
package nn_out_framer_pkg;

  localparam int unsigned SR_ADDR_IN_SIZE  = 129;
  localparam int unsigned SR_ADDR_OUT_SIZE = 130;
  localparam int unsigned SR_ADDR_OUT_LEN  = 131;

  localparam int unsigned CHDR_TUSER_W = 128;
  localparam int unsigned LEN_W        = 16;

  typedef logic [CHDR_TUSER_W-1:0] chdr_tuser_t;

  // A programmed length of zero behaves as single-sample frames.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_W'(1) : len;
  endfunction

endpackage

// File: rtl/nn_out_framer_if.sv
// AXI-stream output bundle from the framer to the packet resizer.
interface nn_out_framer_if #(
  parameter int unsigned WIDTH = 16
);
  import nn_out_framer_pkg::*;

  logic [WIDTH-1:0] tdata;
  chdr_tuser_t      tuser;
  logic             tlast;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tuser, tlast, tvalid, output tready);

endinterface

// File: rtl/nn_sync_fifo.sv
// Small synchronous FIFO with occupancy count; head word is visible on rd_data.
module nn_sync_fifo #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned AWIDTH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic [AWIDTH:0]   count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned DEPTH = 1 << AWIDTH;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic              push;
  logic              pop;

  assign full    = (count == (AWIDTH+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop     = rd_en & ~empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign push    = wr_en & (~full | pop);
  assign rd_data = mem[rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nn_out_framer.sv
// Turns the HLS ap_fifo result port into framed AXI-stream with a re-attached CHDR header.
module nn_out_framer
  import nn_out_framer_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned SR_OUT_LEN = SR_ADDR_OUT_LEN,
  parameter int unsigned DEF_LEN    = 10,
  parameter int unsigned HDR_AWIDTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_stb,
  input  logic [7:0]        set_addr,
  input  logic [31:0]       set_data,
  input  logic [WIDTH-1:0]  res_din,
  input  logic              res_write,
  output logic              res_full_n,
  input  chdr_tuser_t       hdr_tuser,
  input  logic              hdr_tlast,
  input  logic              hdr_beat,
  nn_out_framer_if.master   o,
  output logic [LEN_W-1:0]  out_len,
  output logic              hdr_ovf
);

  logic [WIDTH-1:0]      d_head;
  logic [1:0]            d_count;
  logic                  d_full;
  logic                  d_empty;
  logic                  d_push;

  chdr_tuser_t           h_head;
  logic [HDR_AWIDTH:0]   h_count;
  logic                  h_full;
  logic                  h_empty;
  logic                  h_push;

  logic                  valid;
  logic                  tlast;
  logic                  beat;
  logic                  last_beat;
  logic                  sof;
  logic [LEN_W-1:0]      cnt;
  logic [LEN_W-1:0]      cur_len;
  logic                  unused_bits;

  assign unused_bits = ^{set_data[31:16], d_full, h_count};

  // Flow control looks only at registered occupancy; held low while in reset.
  assign res_full_n = ~reset & (d_count < 2'd2);
  assign d_push     = res_write & res_full_n;

  assign valid     = ~d_empty & ~h_empty;
  assign tlast     = valid & (cnt == cur_len - 1'b1);
  assign beat      = valid & o.tready;
  assign last_beat = beat & tlast;
  assign h_push    = hdr_beat & sof;

  assign o.tdata  = d_head;
  assign o.tuser  = h_head;
  assign o.tlast  = tlast;
  assign o.tvalid = valid;

  nn_sync_fifo #(
    .WIDTH  (WIDTH),
    .AWIDTH (1)
  ) u_data_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (d_push),
    .wr_data (res_din),
    .rd_en   (beat),
    .rd_data (d_head),
    .count   (d_count),
    .full    (d_full),
    .empty   (d_empty)
  );

  nn_sync_fifo #(
    .WIDTH  (CHDR_TUSER_W),
    .AWIDTH (HDR_AWIDTH)
  ) u_hdr_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (h_push),
    .wr_data (hdr_tuser),
    .rd_en   (last_beat),
    .rd_data (h_head),
    .count   (h_count),
    .full    (h_full),
    .empty   (h_empty)
  );

  // Frame-length settings register.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_len <= LEN_W'(DEF_LEN);
    end else if (set_stb && (set_addr == 8'(SR_OUT_LEN))) begin
      out_len <= set_data[15:0];
    end
  end

  // Start-of-packet tracker on the input tap and sticky header overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      sof     <= 1'b1;
      hdr_ovf <= 1'b0;
    end else begin
      if (hdr_beat) begin
        sof <= hdr_tlast;
      end
      if (h_push && h_full && !last_beat) begin
        hdr_ovf <= 1'b1;
      end
    end
  end

  // Sample counter; the frame length is frozen once the first sample of a frame is presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      cur_len <= LEN_W'(DEF_LEN);
    end else begin
      if (last_beat) begin
        cnt <= '0;
      end else if (beat) begin
        cnt <= cnt + 1'b1;
      end
      if (last_beat || ((cnt == '0) && !valid)) begin
        cur_len <= eff_len(out_len);
      end
    end
  end

endmodule
